// File: rtl/linear_tile_engine.sv
// Streaming int8 tile dot-product engine: accumulates K_BEATS beats of N lanes per channel,
// then corrects, requantises and saturates. Optional ReLU clamp via LINEAR_TILE_RELU_EN.
module linear_tile_engine #(
  parameter int              PRECISION              = 8,
  parameter int              BIAS_PRECISION         = 32,
  parameter int              OUTPUT_STAGE_PRECISION = 64,
  parameter int              NUM_FEATURES           = 2,
  parameter int              N                      = 16,
  parameter int              K_BEATS                = 4,
  parameter longint unsigned M_MUL                  = 1073741824,
  parameter int              SHIFT                  = 31,
  parameter int              Z_WEIGHTS              = 5,
  parameter int              Z_OUT                  = 0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              ce,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [BIAS_PRECISION-1:0]                         bias,
  input  logic [N-1:0][PRECISION-1:0]                       weights_in,
  input  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0]     features,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [NUM_FEATURES-1:0][PRECISION-1:0]            out,
  output logic [NUM_FEATURES-1:0][BIAS_PRECISION-1:0]       long_out
);

  // state | meaning
  // ACC   | accepting beats, accumulating dot products and feature sums
  // FIN   | zero-point correction plus bias into long_out
  // RQ    | requantise, add output zero point, saturate into out
  // OUT   | result presented until the consumer accepts it

  localparam int BP    = BIAS_PRECISION;
  localparam int OP    = OUTPUT_STAGE_PRECISION;
  localparam int CNT_W = (K_BEATS > 1) ? $clog2(K_BEATS) : 1;

  localparam logic signed [BP-1:0] ZW   = BP'(Z_WEIGHTS);
  localparam logic signed [OP-1:0] MM   = OP'(M_MUL);
  localparam logic signed [OP-1:0] RND  = OP'(1) <<< (SHIFT - 1);
  localparam logic signed [OP-1:0] ZO   = OP'(Z_OUT);
  localparam logic signed [OP-1:0] QMAX = (OP'(1) <<< (PRECISION - 1)) - OP'(1);
  localparam logic signed [OP-1:0] QMIN = -(OP'(1) <<< (PRECISION - 1));

  typedef enum logic [1:0] {S_ACC, S_FIN, S_RQ, S_OUT} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        beat_cnt;
  logic signed [BP-1:0]    acc      [NUM_FEATURES];
  logic signed [BP-1:0]    ai       [NUM_FEATURES];
  logic signed [BP-1:0]    bias_q;
  logic signed [BP-1:0]    beat_dot [NUM_FEATURES];
  logic signed [BP-1:0]    beat_sum [NUM_FEATURES];
  logic signed [BP-1:0]    corr     [NUM_FEATURES];
  logic signed [OP-1:0]    rq_p     [NUM_FEATURES];
  logic signed [OP-1:0]    rq_q     [NUM_FEATURES];
  logic [PRECISION-1:0]    rq_sat   [NUM_FEATURES];

  logic accept, out_fire, first_beat, last_beat;

  function automatic logic signed [BP-1:0] sx(input logic signed [PRECISION-1:0] v);
    return BP'(v);
  endfunction

  assign in_ready   = ce && (state == S_ACC);
  assign out_valid  = (state == S_OUT);
  assign accept     = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready && ce;
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == CNT_W'(K_BEATS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (accept && last_beat) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_RQ;
      S_RQ:    state_nxt = S_OUT;
      S_OUT:   if (out_fire) state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     state <= S_ACC;
    else if (ce) state <= state_nxt;
  end

  // Per-beat lane reduction, shared weights across channels
  always_comb begin
    for (int c = 0; c < NUM_FEATURES; c++) begin
      beat_dot[c] = '0;
      beat_sum[c] = '0;
      for (int i = 0; i < N; i++) begin
        beat_dot[c] = beat_dot[c] + sx(features[c][i]) * sx(weights_in[i]);
        beat_sum[c] = beat_sum[c] + sx(features[c][i]);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_FEATURES; c++) begin
      corr[c] = acc[c] - ZW * ai[c] + bias_q;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_FEATURES; c++) begin
      rq_p[c]   = OP'($signed(long_out[c])) * MM;
      rq_q[c]   = ((rq_p[c] + RND) >>> SHIFT) + ZO;
`ifdef LINEAR_TILE_RELU_EN
      if (rq_q[c] < ZO) rq_q[c] = ZO;
`endif
      if (rq_q[c] > QMAX)      rq_sat[c] = QMAX[PRECISION-1:0];
      else if (rq_q[c] < QMIN) rq_sat[c] = QMIN[PRECISION-1:0];
      else                     rq_sat[c] = rq_q[c][PRECISION-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      bias_q   <= '0;
      for (int c = 0; c < NUM_FEATURES; c++) begin
        acc[c]      <= '0;
        ai[c]       <= '0;
        long_out[c] <= '0;
        out[c]      <= '0;
      end
    end else if (ce) begin
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
        if (first_beat) bias_q <= bias;
        for (int c = 0; c < NUM_FEATURES; c++) begin
          acc[c] <= first_beat ? beat_dot[c] : acc[c] + beat_dot[c];
          ai[c]  <= first_beat ? beat_sum[c] : ai[c] + beat_sum[c];
        end
      end
      if (state == S_FIN) begin
        for (int c = 0; c < NUM_FEATURES; c++) long_out[c] <= corr[c];
      end
      if (state == S_RQ) begin
        for (int c = 0; c < NUM_FEATURES; c++) out[c] <= rq_sat[c];
      end
    end
  end

endmodule

// File: tb/tb_linear_tile_engine.sv
// Directed self-checking bench for linear_tile_engine; expectations adapt to LINEAR_TILE_RELU_EN.
module tb_linear_tile_engine;
  localparam int P  = 8;
  localparam int BP = 32;
  localparam int NF = 2;
  localparam int N  = 16;
  localparam int K  = 4;
`ifdef LINEAR_TILE_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ce, in_valid, in_ready, out_valid, out_ready;
  logic [BP-1:0]                 bias;
  logic [N-1:0][P-1:0]           weights_in;
  logic [NF-1:0][N-1:0][P-1:0]   features;
  logic [NF-1:0][P-1:0]          out;
  logic [NF-1:0][BP-1:0]         long_out;

  int total = 0;
  int bad   = 0;

  linear_tile_engine dut (
    .clk(clk), .rst(rst), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .bias(bias), .weights_in(weights_in), .features(features),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .long_out(long_out)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int f0, input int f1, input int w, input int b);
    for (int i = 0; i < N; i++) begin
      features[0][i] = 8'(f0);
      features[1][i] = 8'(f1);
      weights_in[i]  = 8'(w);
    end
    bias = 32'(b);
  endtask

  // Non-first beats carry a junk bias that must never be latched.
  task automatic send_vec(input int f0, input int f1, input int w, input int b,
                          input int nbeats, input int gap, input int ce_beat,
                          output int first_wait);
    int t;
    first_wait = -1;
    for (int k = 0; k < nbeats; k++) begin
      load(f0, f1, w, (k == 0) ? b : 305419896);
      in_valid = 1'b1;
      if (k == ce_beat) begin
        ce = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
          $display("FAIL ce_low_ready got=%b want=0", in_ready);
          bad++;
        end
        repeat (3) step();
        ce = 1'b1;
      end
      t = 0;
      #1;
      while (in_ready !== 1'b1 && t < 100) begin
        step();
        t++;
      end
      if (k == 0) first_wait = t;
      if (t >= 100) begin
        total++;
        bad++;
        $display("FAIL beat_timeout beat=%0d got=no_ready want=ready", k);
      end
      step();
      if (gap > 0 && k < nbeats - 1) begin
        in_valid = 1'b0;
        repeat (gap) step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
    if (lat >= 30) begin
      total++;
      bad++;
      $display("FAIL out_timeout got=no_valid want=valid");
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    load(0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
    total++; if (long_out !== '0) begin bad++; $display("FAIL reset_long_out got=%h want=0", long_out); end
  endtask

  task automatic test_basic();
    int fw, lat;
    send_vec(1, 1, 5, 100, K, 0, -1, fw);
    wait_out(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", lat); end
    for (int c = 0; c < NF; c++) begin
      total++; if (long_out[c] !== 32'(100)) begin bad++; $display("FAIL basic_long ch%0d got=%0d want=100", c, $signed(long_out[c])); end
      total++; if (out[c] !== 8'(50)) begin bad++; $display("FAIL basic_out ch%0d got=%0d want=50", c, $signed(out[c])); end
    end
    consume();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b want=1", in_ready); end
  endtask

  task automatic test_rounding();
    int biases [3];
    int exp_o  [3];
    int fw, lat;
    biases = '{101, 1000, -1000};
    exp_o  = '{51, 127, RELU ? 0 : -128};
    for (int j = 0; j < 3; j++) begin
      send_vec(1, 1, 5, biases[j], K, 0, -1, fw);
      wait_out(lat);
      for (int c = 0; c < NF; c++) begin
        total++; if (long_out[c] !== 32'(biases[j])) begin bad++; $display("FAIL round_long b=%0d ch%0d got=%0d want=%0d", biases[j], c, $signed(long_out[c]), biases[j]); end
        total++; if (out[c] !== 8'(exp_o[j])) begin bad++; $display("FAIL round_out b=%0d ch%0d got=%0d want=%0d", biases[j], c, $signed(out[c]), exp_o[j]); end
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int fw, lat;
    send_vec(1, 1, 5, 100, K, 0, -1, fw);
    wait_out(lat);
    load(3, 3, 3, 3);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b want=0", i, in_ready); end
      total++; if (out !== {8'(50), 8'(50)} || long_out !== {32'(100), 32'(100)}) begin
        bad++; $display("FAIL bp_stable cyc=%0d got=%h/%h want=3232/64s", i, out, long_out);
      end
    end
    in_valid = 1'b0;
    consume();
    send_vec(1, 1, 5, 101, K, 0, -1, fw);
    total++; if (fw != 0) begin bad++; $display("FAIL bp_next_accept got=%0d want=0", fw); end
    wait_out(lat);
    for (int c = 0; c < NF; c++) begin
      total++; if (out[c] !== 8'(51)) begin bad++; $display("FAIL bp_next_out ch%0d got=%0d want=51", c, $signed(out[c])); end
    end
    consume();
  endtask

  task automatic test_reset_abort();
    int fw, lat;
    send_vec(3, 3, 3, 999, 2, 0, -1, fw);
    ce = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ce = 1'b1;
    send_vec(1, 1, 5, 100, K, 0, -1, fw);
    wait_out(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL abort_latency got=%0d want=3", lat); end
    for (int c = 0; c < NF; c++) begin
      total++; if (long_out[c] !== 32'(100)) begin bad++; $display("FAIL abort_long ch%0d got=%0d want=100", c, $signed(long_out[c])); end
      total++; if (out[c] !== 8'(50)) begin bad++; $display("FAIL abort_out ch%0d got=%0d want=50", c, $signed(out[c])); end
    end
    consume();
  endtask

  task automatic test_ce_gaps();
    int fw, lat;
    send_vec(1, 1, 5, 100, K, 2, 2, fw);
    wait_out(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL gap_latency got=%0d want=3", lat); end
    for (int c = 0; c < NF; c++) begin
      total++; if (long_out[c] !== 32'(100)) begin bad++; $display("FAIL gap_long ch%0d got=%0d want=100", c, $signed(long_out[c])); end
      total++; if (out[c] !== 8'(50)) begin bad++; $display("FAIL gap_out ch%0d got=%0d want=50", c, $signed(out[c])); end
    end
    ce = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ce_hold_valid got=%b want=1", out_valid); end
    ce = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ce_release_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_channels();
    int fw, lat;
    send_vec(2, -1, 7, 0, K, 0, -1, fw);
    wait_out(lat);
    total++; if (long_out[0] !== 32'(256)) begin bad++; $display("FAIL chan_long ch0 got=%0d want=256", $signed(long_out[0])); end
    total++; if (long_out[1] !== 32'(-128)) begin bad++; $display("FAIL chan_long ch1 got=%0d want=-128", $signed(long_out[1])); end
    total++; if (out[0] !== 8'(127)) begin bad++; $display("FAIL chan_out ch0 got=%0d want=127", $signed(out[0])); end
    total++; if (out[1] !== 8'(RELU ? 0 : -64)) begin bad++; $display("FAIL chan_out ch1 got=%0d want=%0d", $signed(out[1]), RELU ? 0 : -64); end
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_backpressure();
    test_reset_abort();
    test_ce_gaps();
    test_channels();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
